// File: rtl/core_bus_requester_pkg.sv
// Shared definitions for the per-core bus requesters: widths, the
// requester state encoding and the latched bus-cycle record.
package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUS  = 2'd2,
    DONE = 2'd3
  } req_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/core_bus_requester_if.sv
// Core-side handshake, arbiter request/grant and shared-bus signals of one
// requester; master is the requester itself, slave is its environment.
interface core_bus_requester_if;
  import bus_pkg::*;

  logic              core_valid;
  logic              core_ready;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_done;
  logic              core_err;
  logic [DATA_W-1:0] core_rdata;
  logic              req_arb;
  logic              gnt_arb;
  logic              bus_valid;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    input  core_valid, core_we, core_addr, core_wdata,
    input  gnt_arb, bus_rdata, bus_ack,
    output core_ready, core_done, core_err, core_rdata,
    output req_arb, bus_valid, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output core_valid, core_we, core_addr, core_wdata,
    output gnt_arb, bus_rdata, bus_ack,
    input  core_ready, core_done, core_err, core_rdata,
    input  req_arb, bus_valid, bus_we, bus_addr, bus_wdata
  );

endinterface

// File: rtl/core_bus_requester.sv
// Per-core bus initiator: takes one load/store from the core, wins the bus
// through the round-robin arbiter, survives preemption and times out hangs.
module core_bus_requester
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  core_bus_requester_if.master link
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  req_state_t       state;
  bus_req_t         req_q;
  bus_req_t         bus_out;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             bus_fire;
  logic [DATA_W-1:0] rdata_q;
  logic             err_q;

  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign bus_fire  = (state == BUS) && link.gnt_arb && link.bus_ack;

  // Bus drive is gated by state and grant only, never by core inputs.
  assign bus_out         = (state == BUS) ? req_q : '0;
  assign link.bus_valid  = (state == BUS) && link.gnt_arb;
  assign link.bus_we     = bus_out.we;
  assign link.bus_addr   = bus_out.addr;
  assign link.bus_wdata  = bus_out.wdata;
  assign link.req_arb    = (state == REQ) || (state == BUS);
  assign link.core_ready = (state == IDLE);
  assign link.core_done  = (state == DONE);
  assign link.core_rdata = rdata_q;
  assign link.core_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= '0;
      wait_cnt <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (link.core_valid) begin
            req_q    <= '{we: link.core_we, addr: link.core_addr, wdata: link.core_wdata};
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (timed_out) begin
            err_q <= 1'b1;
            state <= DONE;
          end else if (link.gnt_arb) begin
            state <= BUS;
          end
        end
        BUS: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A completing ack beats a timeout landing on the same edge.
          if (bus_fire) begin
            if (!req_q.we) rdata_q <= link.bus_rdata;
            err_q <= 1'b0;
            state <= DONE;
          end else if (timed_out) begin
            err_q <= 1'b1;
            state <= DONE;
          end else if (!link.gnt_arb) begin
            state <= REQ;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_requester.sv
// Directed bench for core_bus_requester: reads, writes, preemption, timeout,
// completion/timeout collision and reset in the middle of a bus cycle.
module tb_core_bus_requester;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  core_bus_requester_if bi();

  core_bus_requester #(.TIMEOUT(64)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (bi)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
    bi.core_valid = 1'b1;
    bi.core_we    = we;
    bi.core_addr  = addr;
    bi.core_wdata = wdata;
  endtask

  initial begin
    int n;
    bi.core_valid = 1'b0;
    bi.core_we    = 1'b0;
    bi.core_addr  = '0;
    bi.core_wdata = '0;
    bi.gnt_arb    = 1'b0;
    bi.bus_ack    = 1'b0;
    bi.bus_rdata  = '0;
    step();
    step();
    rst = 1'b0;

    checkOutput("rst_ready", 32'(bi.core_ready), 32'd1);
    checkOutput("rst_done",  32'(bi.core_done),  32'd0);
    checkOutput("rst_req",   32'(bi.req_arb),    32'd0);
    checkOutput("rst_valid", 32'(bi.bus_valid),  32'd0);
    checkOutput("rst_addr",  32'(bi.bus_addr),   32'd0);
    checkOutput("rst_wdata", bi.bus_wdata,       32'd0);
    checkOutput("rst_we",    32'(bi.bus_we),     32'd0);
    checkOutput("rst_rdata", bi.core_rdata,      32'd0);
    checkOutput("rst_err",   32'(bi.core_err),   32'd0);

    // Read with immediate grant; the ack held during REQ must be ignored.
    applyStimulus(1'b0, 16'h0010, 32'h0);
    step();
    bi.core_valid = 1'b0;
    checkOutput("rd_req",    32'(bi.req_arb),    32'd1);
    checkOutput("rd_nready", 32'(bi.core_ready), 32'd0);
    bi.gnt_arb   = 1'b1;
    bi.bus_ack   = 1'b1;
    bi.bus_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("rd_valid_req", 32'(bi.bus_valid), 32'd0);
    step();
    checkOutput("rd_valid", 32'(bi.bus_valid), 32'd1);
    checkOutput("rd_addr",  32'(bi.bus_addr),  32'h0010);
    checkOutput("rd_we",    32'(bi.bus_we),    32'd0);
    checkOutput("rd_ndone", 32'(bi.core_done), 32'd0);
    step();
    checkOutput("rd_done",   32'(bi.core_done), 32'd1);
    checkOutput("rd_rdata",  bi.core_rdata,     32'hDEADBEEF);
    checkOutput("rd_err",    32'(bi.core_err),  32'd0);
    checkOutput("rd_req_dn", 32'(bi.req_arb),   32'd0);
    checkOutput("rd_bv_dn",  32'(bi.bus_valid), 32'd0);
    bi.gnt_arb = 1'b0;
    bi.bus_ack = 1'b0;
    step();
    checkOutput("rd_ready", 32'(bi.core_ready), 32'd1);
    checkOutput("rd_pulse", 32'(bi.core_done),  32'd0);

    // Write with a grant delayed by five cycles.
    applyStimulus(1'b1, 16'h0200, 32'h12345678);
    step();
    bi.core_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("wr_wait_valid", 32'(bi.bus_valid), 32'd0);
      step();
    end
    bi.gnt_arb = 1'b1;
    step();
    checkOutput("wr_valid", 32'(bi.bus_valid), 32'd1);
    checkOutput("wr_we",    32'(bi.bus_we),    32'd1);
    checkOutput("wr_addr",  32'(bi.bus_addr),  32'h0200);
    checkOutput("wr_wdata", bi.bus_wdata,      32'h12345678);
    step();
    checkOutput("wr_ndone", 32'(bi.core_done), 32'd0);
    bi.bus_ack   = 1'b1;
    bi.bus_rdata = 32'hFFFFFFFF;
    step();
    checkOutput("wr_done",  32'(bi.core_done), 32'd1);
    checkOutput("wr_rdata", bi.core_rdata,     32'hDEADBEEF);
    checkOutput("wr_err",   32'(bi.core_err),  32'd0);
    bi.gnt_arb = 1'b0;
    bi.bus_ack = 1'b0;
    step();
    checkOutput("wr_pulse", 32'(bi.core_done), 32'd0);

    // Preemption: grant drops while ack is high, then the cycle is reissued.
    applyStimulus(1'b0, 16'h0030, 32'h0);
    step();
    bi.core_valid = 1'b0;
    bi.gnt_arb = 1'b1;
    step();
    checkOutput("pre_valid", 32'(bi.bus_valid), 32'd1);
    bi.gnt_arb   = 1'b0;
    bi.bus_ack   = 1'b1;
    bi.bus_rdata = 32'h11111111;
    #1;
    checkOutput("pre_valid_lost", 32'(bi.bus_valid), 32'd0);
    step();
    checkOutput("pre_ndone1", 32'(bi.core_done), 32'd0);
    checkOutput("pre_req",    32'(bi.req_arb),   32'd1);
    checkOutput("pre_bv",     32'(bi.bus_valid), 32'd0);
    step();
    checkOutput("pre_ndone2", 32'(bi.core_done), 32'd0);
    bi.gnt_arb = 1'b1;
    step();
    bi.bus_rdata = 32'hA5A5A5A5;
    #1;
    checkOutput("pre_regrant", 32'(bi.bus_valid), 32'd1);
    step();
    checkOutput("pre_done",  32'(bi.core_done), 32'd1);
    checkOutput("pre_rdata", bi.core_rdata,     32'hA5A5A5A5);
    checkOutput("pre_err",   32'(bi.core_err),  32'd0);
    bi.gnt_arb = 1'b0;
    bi.bus_ack = 1'b0;
    step();

    // Timeout: granted but never acked.
    applyStimulus(1'b0, 16'h0040, 32'h0);
    step();
    bi.core_valid = 1'b0;
    bi.gnt_arb = 1'b1;
    n = 0;
    while (!bi.core_done && n < 100) begin
      step();
      n++;
    end
    checkOutput("to_cycles", 32'(n),           32'd64);
    checkOutput("to_err",    32'(bi.core_err), 32'd1);
    checkOutput("to_rdata",  bi.core_rdata,    32'hA5A5A5A5);
    bi.gnt_arb = 1'b0;
    step();
    checkOutput("to_ready", 32'(bi.core_ready), 32'd1);

    // Ack on the very cycle the counter reaches its limit.
    applyStimulus(1'b0, 16'h0050, 32'h0);
    step();
    bi.core_valid = 1'b0;
    bi.gnt_arb = 1'b1;
    for (int i = 0; i < 63; i++) step();
    checkOutput("col_ndone", 32'(bi.core_done), 32'd0);
    bi.bus_ack   = 1'b1;
    bi.bus_rdata = 32'h5A5A0F0F;
    step();
    checkOutput("col_done",  32'(bi.core_done), 32'd1);
    checkOutput("col_err",   32'(bi.core_err),  32'd0);
    checkOutput("col_rdata", bi.core_rdata,     32'h5A5A0F0F);
    bi.gnt_arb = 1'b0;
    bi.bus_ack = 1'b0;
    step();

    // Reset while driving the bus drops the transaction.
    applyStimulus(1'b1, 16'h0060, 32'h01020304);
    step();
    bi.core_valid = 1'b0;
    bi.gnt_arb = 1'b1;
    step();
    checkOutput("rb_valid", 32'(bi.bus_valid), 32'd1);
    rst = 1'b1;
    step();
    checkOutput("rb_req",   32'(bi.req_arb),    32'd0);
    checkOutput("rb_bv",    32'(bi.bus_valid),  32'd0);
    checkOutput("rb_ready", 32'(bi.core_ready), 32'd1);
    checkOutput("rb_done",  32'(bi.core_done),  32'd0);
    checkOutput("rb_rdata", bi.core_rdata,      32'd0);
    rst = 1'b0;
    bi.gnt_arb = 1'b0;

    // Back-to-back requests: the second is held through DONE.
    applyStimulus(1'b0, 16'h0070, 32'h0);
    step();
    bi.gnt_arb   = 1'b1;
    bi.bus_ack   = 1'b1;
    bi.bus_rdata = 32'hCAFEF00D;
    applyStimulus(1'b0, 16'h0080, 32'h0);
    step();
    step();
    checkOutput("bb_done1",  32'(bi.core_done),  32'd1);
    checkOutput("bb_rdata1", bi.core_rdata,      32'hCAFEF00D);
    checkOutput("bb_nready", 32'(bi.core_ready), 32'd0);
    bi.gnt_arb = 1'b0;
    step();
    checkOutput("bb_ready", 32'(bi.core_ready), 32'd1);
    step();
    bi.core_valid = 1'b0;
    checkOutput("bb_req2", 32'(bi.req_arb),    32'd1);
    checkOutput("bb_nrdy", 32'(bi.core_ready), 32'd0);
    bi.gnt_arb   = 1'b1;
    bi.bus_rdata = 32'h0BADBEEF;
    step();
    checkOutput("bb_addr2", 32'(bi.bus_addr), 32'h0080);
    step();
    checkOutput("bb_done2",  32'(bi.core_done), 32'd1);
    checkOutput("bb_rdata2", bi.core_rdata,     32'h0BADBEEF);
    bi.gnt_arb = 1'b0;
    bi.bus_ack = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/core_bus_requester.md
Name: core_bus_requester

Overview:
- Per-core initiator for the shared memory bus, one instance per core (three in total).
- Accepts one load/store from its core through a valid/ready handshake and requests the bus from the 3-way round-robin arbiter.
- Drives the shared bus only while its grant bit is high, then returns read data or an error to the core.
- Handles loss of grant in mid-transaction and times out hung transactions.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, maximum cycles from acceptance to completion before an error is returned (must be ≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- core_valid  input  1  core presents a request
- core_ready  output  1  block can accept a request
- core_we  input  1  1=write, 0=read
- core_addr  input  ADDR_W  request address
- core_wdata  input  DATA_W  write data
- core_done  output  1  one-cycle completion pulse
- core_err  output  1  qualifies core_done: transaction timed out
- core_rdata  output  DATA_W  read data, valid with core_done
- req_arb  output  1  request to the arbiter (this core's bit)
- gnt_arb  input  1  grant from the arbiter (this core's bit)
- bus_valid  output  1  bus cycle active
- bus_we  output  1  bus write enable
- bus_addr  output  ADDR_W  bus address
- bus_wdata  output  DATA_W  bus write data
- bus_rdata  input  DATA_W  bus read data
- bus_ack  input  1  bus responder completes the cycle

Behaviour:
- Clocking: single clock domain, synchronous active-high reset.
- Reset state: state=IDLE, wait_cnt=0, core_rdata=0, core_err=0.
  - Outputs after reset: core_done=0, req_arb=0, bus_valid=0, bus_addr/bus_wdata/bus_we=0.
- States: IDLE, REQ, BUS, DONE.
- core_ready = (state==IDLE).
- Accept: core_valid&&core_ready on a clock edge latches we/addr/wdata, clears wait_cnt, and moves to REQ.
- Request line: req_arb = state∈{REQ,BUS}. Both req_arb and bus_valid are decoded from registered state; no path from core inputs to the bus.
- REQ:
  - gnt_arb=1 → BUS.
  - Otherwise stay in REQ.
- BUS:
  - bus_valid = gnt_arb. bus_we/addr/wdata drive the latched values in BUS; they are 0 in all other states.
  - Completion: bus_valid&&bus_ack → DONE. In the same edge, capture core_rdata = bus_rdata on a read (unchanged on a write) and set core_err=0.
  - Preemption: gnt_arb=0 → back to REQ, with no completion even if bus_ack=1 in that cycle. The full bus cycle is reissued on the next grant.
- Timeout:
  - wait_cnt increments every cycle in REQ or BUS.
  - If wait_cnt==TIMEOUT-1 and no completion occurs that cycle → DONE with core_err=1; core_rdata is unchanged.
  - Completion and timeout in the same cycle: completion wins, err=0.
- DONE:
  - core_done=1 for exactly one cycle; req_arb=0.
  - Next state is IDLE, so a new request can be accepted one cycle after core_done.
- core_err and core_rdata hold their values until the next completion.
- Latency: accept at edge N, grant present in cycle N+1, ack in the same cycle gives core_done in cycle N+2. Minimum 3 cycles from accept to re-ready.
- A bus_ack seen outside BUS, or while gnt_arb=0, is ignored.
- Reset asserted in any state returns to reset values at the next edge. Any in-flight request is dropped with no core_done.

Decomposition:
- Package bus_pkg holds:
  - ADDR_W and DATA_W defaults.
  - enum req_state_t {IDLE, REQ, BUS, DONE}.
  - struct bus_req_t {we, addr, wdata}, used for the latch and the bus outputs.
- No sub-module. The timeout counter is inline; its width is $clog2(TIMEOUT).

Test Plan:
- Read, immediate grant: read at addr 0x0010; gnt_arb high the cycle after accept; bus_ack with rdata 0xDEADBEEF the same cycle → core_done one cycle later with rdata=0xDEADBEEF, err=0, req_arb low during DONE.
- Write, delayed grant: write 0x12345678 to 0x0200; grant after 5 cycles; ack after 2 more → bus_valid high only once granted, bus_wdata=0x12345678, bus_we=1, a single core_done.
- Preemption: grant, drop gnt_arb for 2 cycles while bus_ack=1, then re-grant and ack with 0xA5A5A5A5 → bus_valid low while ungranted, no completion on the ignored ack, final rdata=0xA5A5A5A5.
- Timeout: never ack with TIMEOUT=64 → core_done with err=1 at exactly 64 cycles after accept; core_ready next cycle.
- Completion and timeout collide: ack on the cycle wait_cnt==63 → err=0, rdata captured.
- Reset mid-BUS: assert rst while bus_valid=1 → next edge req_arb=0, bus_valid=0, core_ready=1, no core_done; then a back-to-back request accepted on the cycle after DONE.
